// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller with line refill.
// Define DCACHE_PERF_CNT_EN to add the saturating hit_cnt / miss_cnt outputs.
module dcache_ctrl #(
    parameter int LINES = 16,
    parameter int WPL   = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          req_rd,
    input  logic                          req_wr,
    input  logic [31:0]                   req_addr,
    input  logic [31:0]                   req_wdata,
    input  logic                          flush,
    input  logic                          mem_ack,
    input  logic [31:0]                   mem_rdata,
`ifdef DCACHE_PERF_CNT_EN
    output logic [31:0]                   hit_cnt,
    output logic [31:0]                   miss_cnt,
`endif
    output logic                          hit,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [31:0]                   mem_addr,
    output logic [31:0]                   mem_wdata,
    output logic                          fill_we,
    output logic [$clog2(LINES*WPL)-1:0]  fill_addr,
    output logic [31:0]                   fill_data
);

    localparam int WORD_BITS = $clog2(WPL);
    localparam int IDX_BITS  = $clog2(LINES);
    localparam int IDX_LSB   = 2 + WORD_BITS;
    localparam int TAG_LSB   = IDX_LSB + IDX_BITS;
    localparam int TAG_BITS  = 32 - TAG_LSB;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [LINES-1:0]     valid_q, valid_d;
    logic [TAG_BITS-1:0]  tag_q [LINES];
    logic [TAG_BITS-1:0]  tag_d [LINES];
    logic [WORD_BITS-1:0] beat_q, beat_d;
    logic [31:0]          base_q, base_d;
    logic [31:0]          waddr_q, waddr_d;
    logic [31:0]          wdata_q, wdata_d;

    logic [IDX_BITS-1:0]  req_idx;
    logic [TAG_BITS-1:0]  req_tag;
    logic [IDX_BITS-1:0]  base_idx;
    logic [TAG_BITS-1:0]  base_tag;
    logic                 lookup_hit;
    logic                 last_beat;

    // A flush in the same cycle forces a miss even if the line is currently valid.
    assign req_idx    = req_addr[IDX_LSB +: IDX_BITS];
    assign req_tag    = req_addr[31:TAG_LSB];
    assign base_idx   = base_q[IDX_LSB +: IDX_BITS];
    assign base_tag   = base_q[31:TAG_LSB];
    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag) && !flush;
    assign last_beat  = (beat_q == {WORD_BITS{1'b1}});

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        beat_d  = beat_q;
        base_d  = base_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    valid_d = '0;
                end
                if (req_wr) begin
                    state_d = S_WRITE;
                    waddr_d = req_addr;
                    wdata_d = req_wdata;
                end else if (req_rd && !lookup_hit) begin
                    // The victim line is invalidated up front so an abandoned refill leaves it invalid.
                    state_d          = S_FILL;
                    beat_d           = '0;
                    base_d           = {req_addr[31:IDX_LSB], {IDX_LSB{1'b0}}};
                    valid_d[req_idx] = 1'b0;
                end
            end
            S_FILL: begin
                if (mem_ack) begin
                    beat_d = beat_q + WORD_BITS'(1);
                    if (last_beat) begin
                        valid_d[base_idx] = 1'b1;
                        tag_d[base_idx]   = base_tag;
                        beat_d            = '0;
                        state_d           = S_IDLE;
                    end
                end
            end
            S_WRITE: begin
                if (mem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            beat_q  <= '0;
            base_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    always_comb begin
        hit       = 1'b1;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = base_q + {{(30-WORD_BITS){1'b0}}, beat_q, 2'b00};
        mem_wdata = wdata_q;
        fill_we   = 1'b0;
        fill_addr = {base_idx, beat_q};
        fill_data = mem_rdata;
        case (state_q)
            S_IDLE: begin
                if (req_wr) begin
                    hit = 1'b0;
                end else if (req_rd) begin
                    hit = lookup_hit;
                end
            end
            S_FILL: begin
                hit     = 1'b0;
                mem_req = 1'b1;
                fill_we = mem_ack;
            end
            S_WRITE: begin
                hit      = mem_ack;
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = waddr_q;
            end
            default: ;
        endcase
    end

`ifdef DCACHE_PERF_CNT_EN
    logic        hit_evt, miss_evt;
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    assign hit_evt  = (state_q == S_IDLE) && !req_wr && req_rd && lookup_hit;
    assign miss_evt = (state_q == S_IDLE) && !req_wr && req_rd && !lookup_hit;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit_evt && (hit_cnt_q != 32'hFFFF_FFFF)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (miss_evt && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter LINES, default 16, number of direct-mapped lines, power of 2.
REQ-002 Parameter WPL, default 4, 32-bit words per line, power of 2.
REQ-003 clock  in  1  single clock; all state changes on posedge clock.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req_rd  in  1  load request from the EXE stage.
REQ-006 req_wr  in  1  store request from the EXE stage.
REQ-007 req_addr  in  32  byte address (ALU result).
REQ-008 req_wdata  in  32  store data.
REQ-009 flush  in  1  invalidate all lines.
REQ-010 hit  out  1  1 = request served this cycle (or no request); 0 = MEM stage stalls.
REQ-011 mem_req / mem_we  out  1 / 1  backing-memory request and write select.
REQ-012 mem_addr / mem_wdata  out  32 / 32  backing-memory word address and write data.
REQ-013 mem_ack / mem_rdata  in  1 / 32  one ack per beat; read data valid with the ack.
REQ-014 fill_we / fill_addr / fill_data  out  1 / log2(LINES*WPL) / 32  data-array refill write port.

Function
REQ-015 Address split: [1:0] ignored; word = next log2(WPL) bits; index = next log2(LINES) bits; tag = the remaining upper bits.
REQ-016 Per line: one valid bit and one tag register. States: IDLE, FILL, WRITE.
REQ-017 IDLE with no request: hit=1, mem_req=0, fill_we=0.
REQ-018 IDLE, req_rd, line valid and tag match: hit=1 in the same cycle (combinational); state stays IDLE.
REQ-019 IDLE, req_rd miss: hit=0; capture the line base address; beat counter cleared; next state FILL.
REQ-020 FILL: mem_req=1, mem_we=0, mem_addr = base + 4*beat; hit=0 throughout.
REQ-021 FILL, mem_ack=1: fill_we=1 in the same cycle; fill_addr = index*WPL + beat; fill_data = mem_rdata; beat increments.
REQ-022 FILL, ack on beat WPL-1: set valid, write tag, enter IDLE. The held request hits on the next cycle, so read-miss latency is WPL ack cycles plus 2.
REQ-023 IDLE, req_wr: write-through, no write-allocate. hit=0; next state WRITE with mem_req=1, mem_we=1, mem_addr=req_addr, mem_wdata=req_wdata, all captured.
REQ-024 WRITE, mem_ack=1: hit=1 in that cycle and state goes to IDLE. The datapath performs any array write (incl. byte/half) gated by hit; valid/tag are unchanged.
REQ-025 req_rd and req_wr both high: treated as a store.
REQ-026 mem_ack while mem_req=0: ignored.
REQ-027 Requests are held stable by the stalled pipeline while hit=0. The controller uses only its captured address in FILL and WRITE.
REQ-028 flush in IDLE: all valid bits clear at the next edge; a read in the same cycle is a miss.
REQ-029 flush in FILL or WRITE: ignored.

Reset
REQ-030 reset low immediately forces: state IDLE, all valid=0, beat=0, mem_req=0, mem_we=0, fill_we=0, captured address/data=0, counters=0. With no request, hit=1.
REQ-031 reset asserted mid-FILL or mid-WRITE: the transaction is abandoned and the partial line stays invalid.

Configuration
REQ-032 Macro DCACHE_PERF_CNT_EN defined: 32-bit outputs hit_cnt and miss_cnt are present.
REQ-033 hit_cnt increments on each REQ-018 hit; miss_cnt increments on each REQ-019 miss entry. Both saturate at 32'hFFFFFFFF.
REQ-034 Macro undefined: hit_cnt and miss_cnt ports and logic are absent; all other behaviour is identical.

Verification
REQ-035 After reset, req_rd addr 0x0000_0040, mem_ack on every cycle with rdata 0xA0..0xA3 -> hit=0 for 5 cycles. fill_addr 16..19 with data 0xA0..0xA3. hit=1 on cycle 6.
REQ-036 Repeat read of 0x0000_0048 -> hit=1 in the same cycle, mem_req stays 0, miss_cnt=1 and hit_cnt=1 (macro on).
REQ-037 req_wr addr 0x0000_0044, wdata 0xDEADBEEF, mem_ack after 3 cycles -> mem_we=1, mem_addr=0x44, hit=1 only in the ack cycle. A following read of 0x40 still hits.
REQ-038 Read 0x0000_0440 (same index, different tag) -> miss and refill from 0x440. A later read of 0x40 misses.
REQ-039 Assert flush in IDLE, then read 0x40 -> miss. Spurious mem_ack in IDLE -> no state change.
REQ-040 Assert reset after 2 FILL beats -> mem_req=0 immediately. After release, a read of the same line misses.
